// File: rtl/tmr_multi_match_if.sv
// ----------------------------------------------------------------------------
// tmr_multi_match_if -- register bus between a host and the tmr_multi_match
// timer.
//
// Signals:
//   sfr_wr_en  write strobe
//   sfr_rd_en  read strobe
//   sfr_addr   5-bit word address
//   sfr_wdata  32-bit write data
//   sfr_rdata  32-bit registered read data (driven by the timer)
//
// Modports: master (host side), slave (timer side).
// ----------------------------------------------------------------------------
interface tmr_multi_match_if;
    logic        sfr_wr_en;
    logic        sfr_rd_en;
    logic [4:0]  sfr_addr;
    logic [31:0] sfr_wdata;
    logic [31:0] sfr_rdata;

    modport master (
        output sfr_wr_en, sfr_rd_en, sfr_addr, sfr_wdata,
        input  sfr_rdata
    );

    modport slave (
        input  sfr_wr_en, sfr_rd_en, sfr_addr, sfr_wdata,
        output sfr_rdata
    );
endinterface

// File: rtl/tmr_multi_match.sv
// ----------------------------------------------------------------------------
// tmr_multi_match -- up-counter with selectable tick source, one-shot mode,
// overflow flag and NUM_MATCH compare channels behind a small register file.
//
// Ports:
//   sys_clk    clock, all state on the rising edge
//   sys_rst_n  synchronous active-low reset
//   tick_in    per-source count enables (bit 0 unused: clksrc 0 counts always)
//   sfr        register bus (tmr_multi_match_if.slave)
//   irq        OR over all sources of (flag AND enable)
//   running    high while the FSM is in RUN
//
// Register map (word address):
//   0 CTRL   on[0] rst[1] ld[2] rd[3] oneshot[4] stop[6] start[7] clksrc[10:8]
//   1 VAL    shadow register (load source / snapshot target)
//   2 IRQ    flags[15:0] (ovf bit 15, matchk bit k, W1C), enables[31:16]
//   3+k      MATCHk
//
// Optional feature macro: TMR_MULTI_MATCH_AUTO_RELOAD_EN -- when defined, the
// counter reloads 0 on the increment after it reaches MATCH0, so channel 0
// sets the period (MATCH0+1 ticks).
// ----------------------------------------------------------------------------
module tmr_multi_match #(
    parameter int TMR_W     = 32,
    parameter int NUM_MATCH = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [7:0]       tick_in,
    tmr_multi_match_if.slave sfr,
    output logic             irq,
    output logic             running
);

    typedef enum logic [1:0] {ST_OFF, ST_STOP, ST_RUN} state_t;

    localparam logic [4:0]       ADDR_CTRL = 5'd0;
    localparam logic [4:0]       ADDR_VAL  = 5'd1;
    localparam logic [4:0]       ADDR_IRQ  = 5'd2;
    localparam logic [TMR_W-1:0] CNT_ONE   = TMR_W'(1);
    localparam logic [TMR_W-1:0] CNT_MAX   = '1;
    localparam logic [15:0]      FLAG_MASK = 16'h8000 | 16'((32'd1 << NUM_MATCH) - 32'd1);

    state_t           state_q, state_next;
    logic             ctrl_on, ctrl_oneshot;
    logic [2:0]       ctrl_clksrc;
    logic             cmd_rst, cmd_ld, cmd_rd, cmd_start, cmd_stop;
    logic [TMR_W-1:0] val_q, cnt_q, cnt_step, cnt_next;
    logic [TMR_W-1:0] match_q [NUM_MATCH];
    logic [15:0]      flags_q, irq_en_q, flag_set, flags_next;
    logic [NUM_MATCH-1:0] match_hit;
    logic [31:0]      rd_mux, rdata_q;
    logic             wr_ctrl, wr_val, wr_irq;
    logic             count_en, do_inc, ovf_set, reload;

    assign wr_ctrl = sfr.sfr_wr_en && (sfr.sfr_addr == ADDR_CTRL);
    assign wr_val  = sfr.sfr_wr_en && (sfr.sfr_addr == ADDR_VAL);
    assign wr_irq  = sfr.sfr_wr_en && (sfr.sfr_addr == ADDR_IRQ);

    // Pending rst/ld win over counting, so an increment only happens without them.
    assign count_en = (state_q == ST_RUN) && ((ctrl_clksrc == 3'd0) || tick_in[ctrl_clksrc]);
    assign do_inc   = count_en && !cmd_rst && !cmd_ld;
    assign ovf_set  = do_inc && (cnt_q == CNT_MAX);

`ifdef TMR_MULTI_MATCH_AUTO_RELOAD_EN
    assign reload = do_inc && (cnt_q == match_q[0]);
`else
    assign reload = 1'b0;
`endif

    assign cnt_step = reload ? '0 : (cnt_q + CNT_ONE);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        match_hit = '0;
        flag_set  = '0;
        for (int k = 0; k < NUM_MATCH; k++) begin
            match_hit[k] = do_inc && (cnt_step == match_q[k]);
            flag_set[k]  = match_hit[k];
        end
        flag_set[15] = ovf_set;
        // A hardware set in the same cycle overrides a W1C.
        flags_next = ((flags_q & ~(wr_irq ? sfr.sfr_wdata[15:0] : 16'h0)) | flag_set) & FLAG_MASK;
    end

    always_comb begin
        cnt_next = cnt_q;
        if (cmd_rst)     cnt_next = '0;
        else if (cmd_ld) cnt_next = val_q;
        else if (do_inc) cnt_next = cnt_step;
    end

    always_comb begin
        state_next = state_q;
        if (!ctrl_on) begin
            state_next = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF:  state_next = ST_STOP;
                ST_STOP: if (cmd_start && !cmd_stop) state_next = ST_RUN;
                ST_RUN:  if (cmd_stop || (ctrl_oneshot && ovf_set)) state_next = ST_STOP;
                default: state_next = ST_OFF;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (sfr.sfr_addr)
            ADDR_CTRL: rd_mux = {21'h0, ctrl_clksrc, 3'h0, ctrl_oneshot, 3'h0, ctrl_on};
            ADDR_VAL:  rd_mux[TMR_W-1:0] = val_q;
            ADDR_IRQ:  rd_mux = {irq_en_q, flags_q};
            default: begin
                for (int k = 0; k < NUM_MATCH; k++) begin
                    if (sfr.sfr_addr == 5'(k + 3)) rd_mux[TMR_W-1:0] = match_q[k];
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q      <= ST_OFF;
            ctrl_on      <= 1'b0;
            ctrl_oneshot <= 1'b0;
            ctrl_clksrc  <= 3'd0;
            cmd_rst      <= 1'b0;
            cmd_ld       <= 1'b0;
            cmd_rd       <= 1'b0;
            cmd_start    <= 1'b0;
            cmd_stop     <= 1'b0;
            val_q        <= '0;
            cnt_q        <= '0;
            flags_q      <= '0;
            irq_en_q     <= '0;
            rdata_q      <= '0;
            // NOTE: the match array is a handful of flops, not a RAM, so it is
            // cleared by reset like every other register.
            for (int k = 0; k < NUM_MATCH; k++) match_q[k] <= '0;
        end else begin
            state_q   <= state_next;
            cnt_q     <= cnt_next;
            flags_q   <= flags_next;
            // Command bits live for exactly one cycle after the CTRL write.
            cmd_rst   <= wr_ctrl && sfr.sfr_wdata[1];
            cmd_ld    <= wr_ctrl && sfr.sfr_wdata[2];
            cmd_rd    <= wr_ctrl && sfr.sfr_wdata[3];
            cmd_stop  <= wr_ctrl && sfr.sfr_wdata[6];
            cmd_start <= wr_ctrl && sfr.sfr_wdata[7];
            if (wr_ctrl) begin
                ctrl_on      <= sfr.sfr_wdata[0];
                ctrl_oneshot <= sfr.sfr_wdata[4];
                ctrl_clksrc  <= sfr.sfr_wdata[10:8];
            end
            if (cmd_rd)      val_q <= cnt_q;
            else if (wr_val) val_q <= sfr.sfr_wdata[TMR_W-1:0];
            if (wr_irq) irq_en_q <= sfr.sfr_wdata[31:16] & FLAG_MASK;
            for (int k = 0; k < NUM_MATCH; k++) begin
                if (sfr.sfr_wr_en && (sfr.sfr_addr == 5'(k + 3)))
                    match_q[k] <= sfr.sfr_wdata[TMR_W-1:0];
            end
            if (sfr.sfr_rd_en) rdata_q <= rd_mux;
        end
    end

    assign sfr.sfr_rdata = rdata_q;
    assign irq           = |(flags_q & irq_en_q);
    assign running       = (state_q == ST_RUN);

endmodule
